// File: rtl/ehgu_basic_pkg.sv
// rtl/ehgu_basic_pkg.sv - shared helpers for the ehgu FIFO blocks
package ehgu_basic_pkg;

    // Classification of one read-return cycle against the in-flight pipe tail.
    typedef enum logic [1:0] {
        RET_NONE        = 2'd0,
        RET_CAPTURE     = 2'd1,
        RET_UNSOLICITED = 2'd2,
        RET_MISSING     = 2'd3
    } ret_kind_e;

    function automatic int mod_inc(input int val, input int modulus);
        return (val >= modulus - 1) ? 0 : val + 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ehgu_fifo_rd_obuf.sv
// rtl/ehgu_fifo_rd_obuf.sv - circular output buffer with push port and show-ahead pop port
module ehgu_fifo_rd_obuf
    import ehgu_basic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            push_valid,
    input  logic [WIDTH-1:0]                push_data,
    output logic                            pop_valid,
    output logic [WIDTH-1:0]                pop_data,
    input  logic                            pop_ready,
    output logic [occ_width(DEPTH)-1:0]     occupancy
);

    localparam int PW = ptr_width(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             pop_fire;

    always_comb begin
        pop_fire = (occ_q != '0) && pop_ready;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        occ_d    = occ_q;
        if (push_valid) begin
            wptr_d = PW'(mod_inc(32'(wptr_q), DEPTH));
        end
        if (pop_fire) begin
            rptr_d = PW'(mod_inc(32'(rptr_q), DEPTH));
        end
        case ({push_valid, pop_fire})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage needs no reset: nothing is visible until occupancy says so.
    always_ff @(posedge clk) begin
        if (push_valid) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign pop_valid = (occ_q != '0);
    assign pop_data  = pop_valid ? mem_q[rptr_q] : '0;
    assign occupancy = occ_q;

endmodule

// File: rtl/ehgu_fifo_rd_stage.sv
// rtl/ehgu_fifo_rd_stage.sv - credit-based FIFO read drain stage with output buffer
module ehgu_fifo_rd_stage
    import ehgu_basic_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int AWIDTH     = 8,
    parameter int RD_LAT     = 1,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [AWIDTH-1:0]                  avail_cnt,
    output logic                               rd_en,
    input  logic [WIDTH-1:0]                   rdata,
    input  logic                               rdata_valid,
    output logic [WIDTH-1:0]                   dout,
    output logic                               dout_valid,
    input  logic                               dout_ready,
    output logic [$clog2(OBUF_DEPTH+1)-1:0]    occupancy,
    output logic                               protocol_err
);

    if (RD_LAT < 1) begin : g_bad_lat
        $error("ehgu_fifo_rd_stage: RD_LAT must be >= 1");
    end
    if (OBUF_DEPTH < RD_LAT + 2) begin : g_bad_depth
        $error("ehgu_fifo_rd_stage: OBUF_DEPTH must be >= RD_LAT+2");
    end

    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic              pop_q, pop_d;
    logic              protocol_err_q, protocol_err_d;
    logic              tail;
    logic              push;
    ret_kind_e         ret_kind;
    int                inflight;
    int                credit;

    always_comb begin
        inflight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + int'(pipe_q[i]);
        end
        // A same-cycle output pop is deliberately not credited until it lands in occupancy.
        credit = OBUF_DEPTH - int'(occupancy) - inflight;
        // pop_q masks the stale avail_cnt that has not yet seen last cycle's pop.
        rd_en  = rstn && (avail_cnt > AWIDTH'(pop_q)) && (credit > 0);
        pop_d  = rd_en;

        pipe_d    = '0;
        pipe_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign tail = pipe_q[RD_LAT-1];

    always_comb begin
        ret_kind = RET_NONE;
        case ({rdata_valid, tail})
            2'b11:   ret_kind = RET_CAPTURE;
            2'b10:   ret_kind = RET_UNSOLICITED;
            2'b01:   ret_kind = RET_MISSING;
            default: ret_kind = RET_NONE;
        endcase
        push           = (ret_kind == RET_CAPTURE);
        protocol_err_d = protocol_err_q
                         || (ret_kind == RET_UNSOLICITED)
                         || (ret_kind == RET_MISSING);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pipe_q         <= '0;
            pop_q          <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            pipe_q         <= pipe_d;
            pop_q          <= pop_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign protocol_err = protocol_err_q;

    ehgu_fifo_rd_obuf #(
        .WIDTH (WIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk        (clk),
        .rstn       (rstn),
        .push_valid (push),
        .push_data  (rdata),
        .pop_valid  (dout_valid),
        .pop_data   (dout),
        .pop_ready  (dout_ready),
        .occupancy  (occupancy)
    );

endmodule
